// File: rtl/elev_pkg.sv
// Shared encodings for the elevator call scheduler: FSM states, floor one-hot
// constants and travel-direction values.
package elev_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_SERVE = 2'd3
  } state_e;

  localparam logic [3:1] FL_NONE = 3'b000;
  localparam logic [3:1] FL1     = 3'b001;
  localparam logic [3:1] FL2     = 3'b010;
  localparam logic [3:1] FL3     = 3'b100;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  function automatic logic is_onehot(input logic [3:1] f);
    return (f == FL1) || (f == FL2) || (f == FL3);
  endfunction

endpackage

// File: rtl/elev_target_sel.sv
// Combinational target selection: which pending floors lie above/below/at the
// car, and the closest pending floor on each side.
module elev_target_sel
  import elev_pkg::*;
(
  input  logic [3:1] pending,
  input  logic [3:1] floor,
  input  logic       dir,
  output logic       above,
  output logic       below,
  output logic       here,
  output logic       pref_up,
  output logic [3:1] near_above,
  output logic [3:1] near_below
);

  logic [3:1] above_mask;
  logic [3:1] below_mask;
  logic [3:1] pend_above;
  logic [3:1] pend_below;

  always_comb begin
    above_mask = {floor[2] | floor[1], floor[1], 1'b0};
    below_mask = {1'b0, floor[3], floor[3] | floor[2]};
    pend_above = pending & above_mask;
    pend_below = pending & below_mask;
    above      = |pend_above;
    below      = |pend_below;
    here       = |(pending & floor);
    near_above = pend_above[2] ? FL2 : (pend_above[3] ? FL3 : FL_NONE);
    near_below = pend_below[2] ? FL2 : (pend_below[1] ? FL1 : FL_NONE);
    // Head up after a stop: keep going up if travelling up, else only when nothing is below.
    pref_up    = (dir == DIR_UP) ? above : (above && !below);
  end

endmodule

// File: rtl/elev_call_scheduler.sv
// Three-floor elevator call scheduler with registered request/direction outputs.
// Optional home return to floor 1 after idling: define ELEV_SCHED_HOME_EN.
module elev_call_scheduler
  import elev_pkg::*;
#(
  parameter int unsigned IDLE_CYCLES = 16
)
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:1] call,
  input  logic [3:1] floor,
  input  logic       door,
  output logic [3:1] req,
  output logic [3:1] pending,
  output logic       dir,
  output logic       busy
);

  state_e     state, state_next;
  logic [3:1] req_next, pending_next, home_set;
  logic       dir_next, door_q;
  logic       above, below, here, pref_up;
  logic [3:1] near_above, near_below;

  elev_target_sel u_target_sel (
    .pending    (pending),
    .floor      (floor),
    .dir        (dir),
    .above      (above),
    .below      (below),
    .here       (here),
    .pref_up    (pref_up),
    .near_above (near_above),
    .near_below (near_below)
  );

`ifdef ELEV_SCHED_HOME_EN
  localparam int unsigned CW = $clog2(IDLE_CYCLES + 1);
  logic [CW-1:0] idle_cnt;
  logic          idle_qual, idle_done;

  assign idle_qual = (state == ST_IDLE) && (pending == FL_NONE) &&
                     (call == FL_NONE) && (floor != FL1);
  assign idle_done = idle_qual && (idle_cnt == CW'(IDLE_CYCLES - 1));
  assign home_set  = idle_done ? FL1 : FL_NONE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        idle_cnt <= '0;
    else if (!idle_qual || idle_done) idle_cnt <= '0;
    else                              idle_cnt <= idle_cnt + 1'b1;
  end
`else
  logic unused_idle_cfg;
  assign unused_idle_cfg = ^IDLE_CYCLES;
  assign home_set        = FL_NONE;
`endif

  // An open door at a floor absorbs any call for that floor on the same cycle.
  assign pending_next = (pending | call | home_set) & ~(door ? floor : FL_NONE);

  always_comb begin
    state_next = state;
    req_next   = FL_NONE;
    dir_next   = dir;
    if (is_onehot(floor)) begin
      // With three floors "nearest, ties go up" reduces to "above wins".
      case (state)
        ST_IDLE: begin
          if (here)       state_next = ST_SERVE;
          else if (above) state_next = ST_UP;
          else if (below) state_next = ST_DOWN;
        end
        ST_UP: begin
          if (here)       state_next = ST_SERVE;
          else if (above) state_next = ST_UP;
          else if (below) state_next = ST_DOWN;
          else            state_next = ST_IDLE;
        end
        ST_DOWN: begin
          if (here)       state_next = ST_SERVE;
          else if (below) state_next = ST_DOWN;
          else if (above) state_next = ST_UP;
          else            state_next = ST_IDLE;
        end
        default: begin
          if (door_q && !door) begin
            if (here)         state_next = ST_SERVE;
            else if (pref_up) state_next = ST_UP;
            else if (below)   state_next = ST_DOWN;
            else              state_next = ST_IDLE;
          end
        end
      endcase
      case (state_next)
        ST_SERVE: req_next = floor;
        ST_UP: begin
          req_next = near_above;
          dir_next = DIR_UP;
        end
        ST_DOWN: begin
          req_next = near_below;
          dir_next = DIR_DOWN;
        end
        default: req_next = FL_NONE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      pending <= FL_NONE;
      req     <= FL_NONE;
      dir     <= DIR_UP;
      busy    <= 1'b0;
      door_q  <= 1'b0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      req     <= req_next;
      dir     <= dir_next;
      busy    <= (state_next != ST_IDLE);
      door_q  <= door;
    end
  end

endmodule

// File: tb/tb_elev_call_scheduler.sv
// Scoreboard bench for elev_call_scheduler: directed scenarios plus random
// traffic, each cycle checked against a floor-number reference model.
module tb_elev_call_scheduler;

  localparam int unsigned IDLE_N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:1] call = 3'b000;
  logic [3:1] floor = 3'b001;
  logic       door = 1'b0;
  logic [3:1] req, pending;
  logic       dir, busy;

  elev_call_scheduler #(.IDLE_CYCLES(IDLE_N)) dut (
    .clk     (clk),
    .reset   (reset),
    .call    (call),
    .floor   (floor),
    .door    (door),
    .req     (req),
    .pending (pending),
    .dir     (dir),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:1] req;
    logic [3:1] pend;
    logic       dir;
    logic       busy;
  } obs_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: floors are numbers 1..3, 0 means "no valid floor/target".
  typedef enum {M_IDLE, M_UP, M_DOWN, M_SERVE} mode_e;
  mode_e m_mode = M_IDLE;
  bit    m_pend[1:3];
  int    m_req = 0;
  bit    m_dir = 1'b1;
  bit    m_door_prev = 1'b0;
  int    m_cnt = 0;

  function automatic int floor_num(input logic [3:1] f);
    if (f === 3'b001) return 1;
    if (f === 3'b010) return 2;
    if (f === 3'b100) return 3;
    return 0;
  endfunction

  // Decide where to go from floor n given nearest pending above (a) and below (b).
  function automatic mode_e pick(input bit here, input int a, input int b, input int n,
                                 input bit use_dir, input bit d);
    if (here) return M_SERVE;
    if (a != 0 && b != 0) begin
      if (use_dir) return d ? M_UP : M_DOWN;
      return ((a - n) <= (n - b)) ? M_UP : M_DOWN;
    end
    if (a != 0) return M_UP;
    if (b != 0) return M_DOWN;
    return M_IDLE;
  endfunction

  task automatic model_step(input logic [3:1] c, input logic [3:1] f, input logic d,
                            input logic r);
    int n, a, b;
    bit any, home;
    if (r) begin
      m_mode = M_IDLE;
      for (int i = 1; i <= 3; i++) m_pend[i] = 1'b0;
      m_req = 0; m_dir = 1'b1; m_door_prev = 1'b0; m_cnt = 0;
      return;
    end
    any = m_pend[1] | m_pend[2] | m_pend[3];
    home = 1'b0;
`ifdef ELEV_SCHED_HOME_EN
    if (m_mode == M_IDLE && !any && c == 3'b000 && f != 3'b001) begin
      m_cnt++;
      if (m_cnt == IDLE_N) begin home = 1'b1; m_cnt = 0; end
    end else m_cnt = 0;
`endif
    n = floor_num(f);
    if (n == 0) m_req = 0;
    else begin
      a = 0; b = 0;
      for (int i = n + 1; i <= 3; i++) if (m_pend[i] && a == 0) a = i;
      for (int i = n - 1; i >= 1; i--) if (m_pend[i] && b == 0) b = i;
      case (m_mode)
        M_IDLE:  m_mode = pick(m_pend[n], a, b, n, 1'b0, m_dir);
        M_UP:    m_mode = pick(m_pend[n], a, b, n, 1'b1, 1'b1);
        M_DOWN:  m_mode = pick(m_pend[n], a, b, n, 1'b1, 1'b0);
        default: if (m_door_prev && !d) m_mode = pick(m_pend[n], a, b, n, 1'b1, m_dir);
      endcase
      case (m_mode)
        M_SERVE: m_req = n;
        M_UP:    begin m_req = a; m_dir = 1'b1; end
        M_DOWN:  begin m_req = b; m_dir = 1'b0; end
        default: m_req = 0;
      endcase
    end
    for (int i = 1; i <= 3; i++) begin
      if (c[i] || (i == 1 && home)) m_pend[i] = 1'b1;
      if (d && f[i]) m_pend[i] = 1'b0;
    end
    m_door_prev = d;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.req = 3'b000;
    if (m_req > 0) o.req[m_req] = 1'b1;
    for (int i = 1; i <= 3; i++) o.pend[i] = m_pend[i];
    o.dir  = m_dir;
    o.busy = (m_mode != M_IDLE);
    return o;
  endfunction

  // One stimulus cycle: drive after the sampling edge, advance model on the clock.
  task automatic step(input logic [3:1] c, input logic [3:1] f, input logic d, input logic r);
    @(negedge clk);
    #1;
    call = c; floor = f; door = d; reset = r;
    @(posedge clk);
    model_step(c, f, d, r);
    exp_q.push_back(model_obs());
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {req, pending, dir, busy};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL scoreboard @%0t: got req=%b pend=%b dir=%b busy=%b expected req=%b pend=%b dir=%b busy=%b",
                   $time, a.req, a.pend, a.dir, a.busy, e.req, e.pend, e.dir, e.busy);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    logic [3:1] cur_f, c;
    logic       d, r;
    int         sel;

    // Calls during reset are ignored.
    step(3'b100, 3'b001, 1'b0, 1'b1);
    step(3'b100, 3'b001, 1'b0, 1'b1);
    step(3'b000, 3'b001, 1'b0, 1'b0);
    chk("reset_pending", {1'b0, pending}, 4'b0000);
    chk("reset_req",     {1'b0, req},     4'b0000);
    chk("reset_busy",    {3'b0, busy},    4'b0000);
    chk("reset_dir",     {3'b0, dir},     4'b0001);

    // Single call from floor 1 to floor 3.
    step(3'b100, 3'b001, 1'b0, 1'b0);
    chk("single_pending", {1'b0, pending}, 4'b0100);
    step(3'b000, 3'b001, 1'b0, 1'b0);
    chk("single_req", {1'b0, req}, 4'b0100);
    chk("single_dir", {3'b0, dir}, 4'b0001);
    step(3'b000, 3'b100, 1'b0, 1'b0);
    chk("single_serve_req", {1'b0, req}, 4'b0100);
    step(3'b000, 3'b100, 1'b1, 1'b0);
    step(3'b000, 3'b100, 1'b0, 1'b0);
    chk("single_done_pend", {1'b0, pending}, 4'b0000);
    chk("single_done_busy", {3'b0, busy}, 4'b0000);

    // Tie at floor 2 goes up, then direction preference after serving floor 3.
    step(3'b000, 3'b010, 1'b0, 1'b1);
    step(3'b101, 3'b010, 1'b0, 1'b0);
    step(3'b000, 3'b010, 1'b0, 1'b0);
    chk("tie_req", {1'b0, req}, 4'b0100);
    step(3'b000, 3'b100, 1'b0, 1'b0);
    chk("pref_serve3", {1'b0, req}, 4'b0100);
    step(3'b000, 3'b100, 1'b1, 1'b0);
    step(3'b000, 3'b100, 1'b0, 1'b0);
    chk("pref_down_req", {1'b0, req}, 4'b0001);
    chk("pref_down_dir", {3'b0, dir}, 4'b0000);
    step(3'b000, 3'b001, 1'b0, 1'b0);
    step(3'b000, 3'b001, 1'b1, 1'b0);
    step(3'b000, 3'b001, 1'b0, 1'b0);
    chk("pref_end_busy", {3'b0, busy}, 4'b0000);

    // Open door at floor 2 absorbs a call for floor 2.
    step(3'b000, 3'b010, 1'b0, 1'b1);
    step(3'b010, 3'b010, 1'b1, 1'b0);
    chk("clear_wins", {1'b0, pending}, 4'b0000);

    // Mid-travel retarget, then reset mid-travel with no replay.
    step(3'b000, 3'b001, 1'b0, 1'b1);
    step(3'b100, 3'b001, 1'b0, 1'b0);
    step(3'b000, 3'b001, 1'b0, 1'b0);
    step(3'b010, 3'b001, 1'b0, 1'b0);
    step(3'b000, 3'b001, 1'b0, 1'b0);
    chk("retarget_req", {1'b0, req}, 4'b0010);
    step(3'b000, 3'b010, 1'b0, 1'b1);
    chk("midreset_pend", {1'b0, pending}, 4'b0000);
    chk("midreset_busy", {3'b0, busy}, 4'b0000);
    repeat (3) step(3'b000, 3'b010, 1'b0, 1'b0);
    chk("noreplay_req", {1'b0, req}, 4'b0000);

    // Idle at floor 3 with no calls.
    step(3'b000, 3'b100, 1'b0, 1'b1);
`ifdef ELEV_SCHED_HOME_EN
    repeat (IDLE_N) step(3'b000, 3'b100, 1'b0, 1'b0);
    chk("home_pending", {1'b0, pending}, 4'b0001);
    step(3'b000, 3'b100, 1'b0, 1'b0);
    chk("home_req", {1'b0, req}, 4'b0001);
`else
    repeat (100) step(3'b000, 3'b100, 1'b0, 1'b0);
    chk("stay_req", {1'b0, req}, 4'b0000);
    chk("stay_pending", {1'b0, pending}, 4'b0000);
`endif

    // Random traffic.
    step(3'b000, 3'b001, 1'b0, 1'b1);
    cur_f = 3'b001;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        sel = int'($urandom_range(0, 19));
        if (sel == 0)      cur_f = 3'b000;
        else if (sel == 1) cur_f = 3'b011;
        else if (sel < 8)  cur_f = 3'b001;
        else if (sel < 14) cur_f = 3'b010;
        else               cur_f = 3'b100;
      end
      c = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      d = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 299) == 0);
      step(c, cur_f, d, r);
    end

    repeat (3) @(negedge clk);
    #1;
    chk("queue_drained", 4'(exp_q.size()), 4'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
